// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   state_e      : sequencer states (IDLE / ACCESS / RESP)
//   ARB_FIXED    : fixed-priority policy selector (requester 0 always wins)
//   ARB_RR       : round-robin policy selector
//   req_idx_t    : requester index (0 = load/store unit, 1 = DMA/debug)
//   TMO_W        : width of the ACCESS wait counter
//   addr_misaligned() : helper used by the optional alignment check
// Optional feature macro used by the slice: DMEM_ARB_ALIGN_CHECK_EN
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef logic req_idx_t;

  localparam int TMO_W = 8;
  typedef logic [TMO_W-1:0] tmo_cnt_t;

  // A word access is aligned only when the two byte-offset bits are zero.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational two-way picker, reusable for any two-requester shared
// resource.
//   stb0_i, stb1_i : request lines
//   last_grant_i   : index granted most recently (round-robin history)
//   mode_i         : ARB_FIXED or ARB_RR
//   valid_o        : at least one request present
//   grant_o        : index of the winning requester (only meaningful with
//                    valid_o)
// -----------------------------------------------------------------------------
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     stb0_i,
  input  logic     stb1_i,
  input  req_idx_t last_grant_i,
  input  logic     mode_i,
  output logic     valid_o,
  output req_idx_t grant_o
);

  // Winner selection: a lone requester always wins; a tie goes to requester 0
  // in fixed mode, or to the one not granted last time in round-robin mode.
  always_comb begin
    valid_o = stb0_i | stb1_i;
    grant_o = 1'b0;
    if (stb0_i && stb1_i) begin
      if (mode_i == ARB_RR) begin
        grant_o = ~last_grant_i;
      end else begin
        grant_o = 1'b0;
      end
    end else if (stb1_i) begin
      grant_o = 1'b1;
    end else begin
      grant_o = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter and sequencer in front of the single-port data memory.
// Requester 0 is the core load/store unit, requester 1 the DMA/debug port.
// One transaction at a time: IDLE (arbitrate, latch request) -> ACCESS (wait
// for i_mem_rd_ack or timeout) -> RESP (one-cycle ack to the winner).
//
// Parameters
//   ARB_MODE    : 0 = fixed priority (M0 wins), 1 = round-robin
//   TIMEOUT_CYC : ACCESS cycles without i_mem_rd_ack before an error response
//                 (1..255)
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   i_mX_stb/wr_en/addr/wdata: request from requester X (held until ack)
//   o_mX_ack/err/rdata       : one-cycle completion with error flag and data
//   o_mem_stb/wr_en/addr/wdata: registered memory command
//   i_mem_rd_ack, i_mem_rdata: memory ready and combinational read data
//
// Optional feature: define DMEM_ARB_ALIGN_CHECK_EN to reject word-misaligned
// addresses without touching the memory (err response one cycle after grant).
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_m0_stb,
  input  logic        i_m0_wr_en,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rdata,

  input  logic        i_m1_stb,
  input  logic        i_m1_wr_en,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rdata,

  output logic        o_mem_stb,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rd_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic     MODE_BIT = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;
  // The counter holds the number of ACCESS cycles already spent waiting, so
  // the last permitted waiting cycle is the one where it equals TIMEOUT_CYC-1.
  localparam tmo_cnt_t TMO_LAST = tmo_cnt_t'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  req_idx_t    winner_q, winner_d;
  req_idx_t    last_grant_q, last_grant_d;
  tmo_cnt_t    cnt_q, cnt_d;

  logic        mem_stb_q, mem_stb_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        m0_ack_q, m0_ack_d;
  logic        m0_err_q, m0_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic        m1_ack_q, m1_ack_d;
  logic        m1_err_q, m1_err_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        pick_valid_s;
  req_idx_t    pick_idx_s;
  logic        sel_wr_en_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        misaligned_s;
  logic        timeout_s;

  dmem_arb_pick u_pick (
    .stb0_i       (i_m0_stb),
    .stb1_i       (i_m1_stb),
    .last_grant_i (last_grant_q),
    .mode_i       (MODE_BIT),
    .valid_o      (pick_valid_s),
    .grant_o      (pick_idx_s)
  );

  // Route the winning requester's command fields toward the memory registers.
  always_comb begin
    if (pick_idx_s == 1'b1) begin
      sel_wr_en_s = i_m1_wr_en;
      sel_addr_s  = i_m1_addr;
      sel_wdata_s = i_m1_wdata;
    end else begin
      sel_wr_en_s = i_m0_wr_en;
      sel_addr_s  = i_m0_addr;
      sel_wdata_s = i_m0_wdata;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misaligned_s = addr_misaligned(sel_addr_s);
`else
  assign misaligned_s = 1'b0;
`endif

  // rd_ack takes precedence over a timeout landing in the same cycle.
  assign timeout_s = !i_mem_rd_ack && (cnt_q == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          if (misaligned_s) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (i_mem_rd_ack || timeout_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values. Response registers default to zero so an
  // ack, and its err/rdata, last exactly one cycle and the non-winner stays 0.
  // The request is latched at grant, so a requester dropping stb early cannot
  // disturb a transaction already in flight.
  always_comb begin
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_stb_d    = mem_stb_q;
    mem_wr_en_d  = mem_wr_en_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    m0_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m0_rdata_d   = 32'h0000_0000;
    m1_ack_d     = 1'b0;
    m1_err_d     = 1'b0;
    m1_rdata_d   = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          winner_d     = pick_idx_s;
          last_grant_d = pick_idx_s;
          cnt_d        = {TMO_W{1'b0}};
          if (misaligned_s) begin
            // Rejected without a memory cycle: straight to an error response.
            mem_stb_d   = 1'b0;
            mem_wr_en_d = 1'b0;
            if (pick_idx_s == 1'b1) begin
              m1_ack_d = 1'b1;
              m1_err_d = 1'b1;
            end else begin
              m0_ack_d = 1'b1;
              m0_err_d = 1'b1;
            end
          end else begin
            mem_stb_d   = 1'b1;
            mem_wr_en_d = sel_wr_en_s;
            mem_addr_d  = sel_addr_s;
            mem_wdata_d = sel_wdata_s;
          end
        end else begin
          mem_stb_d   = 1'b0;
          mem_wr_en_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (i_mem_rd_ack) begin
          mem_stb_d   = 1'b0;
          mem_wr_en_d = 1'b0;
          if (winner_q == 1'b1) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = mem_wr_en_q ? 32'h0000_0000 : i_mem_rdata;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = mem_wr_en_q ? 32'h0000_0000 : i_mem_rdata;
          end
        end else if (timeout_s) begin
          mem_stb_d   = 1'b0;
          mem_wr_en_d = 1'b0;
          if (winner_q == 1'b1) begin
            m1_ack_d = 1'b1;
            m1_err_d = 1'b1;
          end else begin
            m0_ack_d = 1'b1;
            m0_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + tmo_cnt_t'(1);
        end
      end

      ST_RESP: begin
        cnt_d       = {TMO_W{1'b0}};
        mem_stb_d   = 1'b0;
        mem_wr_en_d = 1'b0;
      end

      default: begin
        cnt_d       = {TMO_W{1'b0}};
        mem_stb_d   = 1'b0;
        mem_wr_en_d = 1'b0;
      end
    endcase
  end

  // Datapath and response registers. Reset leaves last_grant at 1 so that
  // requester 0 wins the first round-robin tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= {TMO_W{1'b0}};
      mem_stb_q    <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m0_rdata_q   <= 32'h0000_0000;
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m1_rdata_q   <= 32'h0000_0000;
    end else begin
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_stb_q    <= mem_stb_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      m0_ack_q     <= m0_ack_d;
      m0_err_q     <= m0_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_ack_q     <= m1_ack_d;
      m1_err_q     <= m1_err_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign o_mem_stb   = mem_stb_q;
  assign o_mem_wr_en = mem_wr_en_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_m0_ack    = m0_ack_q;
  assign o_m0_err    = m0_err_q;
  assign o_m0_rdata  = m0_rdata_q;
  assign o_m1_ack    = m1_ack_q;
  assign o_m1_err    = m1_err_q;
  assign o_m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance against a small memory model
// with a scoreboard of expected responses, plus a fixed-priority instance for
// the starvation-order sequence.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Round-robin DUT signals
  logic        m0_stb = 1'b0, m0_wr = 1'b0;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
  logic        m1_stb = 1'b0, m1_wr = 1'b0;
  logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_stb, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b1;
  logic [31:0] mem [0:255];

  // Fixed-priority DUT signals
  logic        f_m0_stb = 1'b0, f_m1_stb = 1'b0;
  logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_mem_stb, f_mem_wr_en;
  logic [31:0] f_mem_addr, f_mem_wdata;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          stb_cnt;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          stb_cnt;
  } vec_t;

  exp_t exp_q[$];

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam logic AL_ERR = 1'b1;
  localparam int   AL_LAT = 1;
  localparam int   AL_STB = 0;
`else
  localparam logic AL_ERR = 1'b0;
  localparam int   AL_LAT = 2;
  localparam int   AL_STB = 1;
`endif

  dmem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .i_m0_stb(m0_stb), .i_m0_wr_en(m0_wr), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
    .i_m1_stb(m1_stb), .i_m1_wr_en(m1_wr), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
    .o_mem_stb(mem_stb), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rd_ack(mem_ready), .i_mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(15)) dut_fix (
    .clk(clk), .rst(rst),
    .i_m0_stb(f_m0_stb), .i_m0_wr_en(1'b0), .i_m0_addr(32'h0000_0040), .i_m0_wdata(32'h0),
    .o_m0_ack(f_m0_ack), .o_m0_err(f_m0_err), .o_m0_rdata(f_m0_rdata),
    .i_m1_stb(f_m1_stb), .i_m1_wr_en(1'b0), .i_m1_addr(32'h0000_0080), .i_m1_wdata(32'h0),
    .o_m1_ack(f_m1_ack), .o_m1_err(f_m1_err), .o_m1_rdata(f_m1_rdata),
    .o_mem_stb(f_mem_stb), .o_mem_wr_en(f_mem_wr_en), .o_mem_addr(f_mem_addr),
    .o_mem_wdata(f_mem_wdata), .i_mem_rd_ack(1'b1), .i_mem_rdata(32'h1234_5678)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: pattern-filled while reset is high, writes only when ready.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
    end else if (mem_stb && mem_wr_en && mem_ready) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: counts memory strobe cycles per transaction and pops
  // one expected record per ack.
  initial begin : monitor
    int          stb_cnt;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_wr;
    exp_t        e;
    stb_cnt = 0; cap_addr = 32'h0; cap_wdata = 32'h0; cap_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stb_cnt = 0;
      end else begin
        if (mem_stb) begin
          if (stb_cnt == 0) begin
            cap_addr = mem_addr; cap_wr = mem_wr_en; cap_wdata = mem_wdata;
          end
          stb_cnt++;
        end
        if (m0_ack || m1_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(m1_ack), 32'(m0_ack) + 32'd2);
          end else begin
            e = exp_q.pop_front();
            chk("ack_idx", 32'(m1_ack), 32'(e.idx));
            chk("ack_both", 32'(m0_ack & m1_ack), 32'd0);
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            chk("err", 32'(e.idx == 1 ? m1_err : m0_err), 32'(e.err));
            chk("rdata", e.idx == 1 ? m1_rdata : m0_rdata, e.rdata);
            chk("other_resp_zero", e.idx == 1 ? (m0_rdata | 32'(m0_err)) : (m1_rdata | 32'(m1_err)), 32'd0);
            chk("mem_stb_cycles", 32'(stb_cnt), 32'(e.stb_cnt));
            if (e.stb_cnt != 0) begin
              chk("mem_addr", cap_addr, e.addr);
              chk("mem_wr_en", 32'(cap_wr), 32'(e.wr));
              if (e.wr) chk("mem_wdata", cap_wdata, e.wdata);
            end
          end
          stb_cnt = 0;
        end else begin
          chk("idle_resp_zero", m0_rdata | m1_rdata | 32'(m0_err) | 32'(m1_err), 32'd0);
        end
      end
    end
  end

  // Drive a request from requester idx for a number of rounds; each round is
  // raised at a negedge and dropped in the cycle its ack is seen.
  task automatic req_loop(input int idx, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rounds, input bit push,
                          input int lat, input logic err, input logic [31:0] rdata,
                          input int stbc);
    bit   seen;
    exp_t e;
    for (int r = 0; r < rounds; r++) begin
      if (r > 0) @(negedge clk);
      if (idx == 0) begin
        m0_stb = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
      end else begin
        m1_stb = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
      end
      if (push) begin
        e.idx = idx; e.err = err; e.rdata = rdata; e.cyc = cyc + lat;
        e.stb_cnt = stbc; e.addr = addr; e.wr = wr; e.wdata = wdata;
        exp_q.push_back(e);
      end
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        @(negedge clk);
        seen = (idx == 0) ? m0_ack : m1_ack;
      end
      chk("ack_seen", 32'(seen), 32'd1);
      if (idx == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
    end
  endtask

  task automatic push_exp(input int idx, input int c, input logic [31:0] rdata,
                          input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    exp_t e;
    e.idx = idx; e.err = 1'b0; e.rdata = rdata; e.cyc = c; e.stb_cnt = 1;
    e.addr = addr; e.wr = wr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[10];
    int   k, f0, f1;
    bit   seen;

    vecs[0] = '{0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         2, 1};
    vecs[1] = '{0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 2, 1};
    vecs[2] = '{1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,         2, 1};
    vecs[3] = '{1, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D, 2, 1};
    vecs[4] = '{0, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D, 2, 1};
    vecs[5] = '{1, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 1'b1, 32'h0,        16, 15};
    vecs[6] = '{1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 2, 1};
    vecs[7] = '{0, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0,         2, 1};
    vecs[8] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b0, 32'h0BAD_F00D, 2, 1};
    vecs[9] = '{0, 1'b1, 32'h0000_0102, 32'h1111_2222, 1'b1, AL_ERR, 32'h0,  AL_LAT, AL_STB};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_stb", 32'(mem_stb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata | mem_wdata, 32'd0);
    rst = 1'b0;

    // Round-robin: both read from reset, four rounds each, strictly alternating.
    @(negedge clk);
    k = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push_exp(0, k + 2 + 3 * i, 32'h5A00_0004, 32'h0000_0010, 1'b0, 32'h0);
      else            push_exp(1, k + 2 + 3 * i, 32'h5A00_0008, 32'h0000_0020, 1'b0, 32'h0);
    end
    fork
      req_loop(0, 1'b0, 32'h0000_0010, 32'h0, 4, 1'b0, 0, 1'b0, 32'h0, 0);
      req_loop(1, 1'b0, 32'h0000_0020, 32'h0, 4, 1'b0, 0, 1'b0, 32'h0, 0);
    join

    // Table of single transactions
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = vecs[i].ready;
      req_loop(vecs[i].idx, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1, 1'b1,
               vecs[i].lat, vecs[i].err, vecs[i].rdata, vecs[i].stb_cnt);
    end

    // Reset in the middle of an M0 write
    @(negedge clk);
    mem_ready = 1'b1;
    m0_stb = 1'b1; m0_wr = 1'b1; m0_addr = 32'h0000_0300; m0_wdata = 32'h7777_0000;
    @(negedge clk);
    chk("pre_rst_access_stb", 32'(mem_stb), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_mem_stb", 32'({mem_stb, mem_wr_en}), 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    chk("async_rst_mem_wdata", mem_wdata, 32'd0);
    chk("async_rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    m0_stb = 1'b0; m0_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // After reset M0 must win a tie again, then its write is read back.
    @(negedge clk);
    k = cyc;
    push_exp(0, k + 2, 32'h0, 32'h0000_0300, 1'b1, 32'h7777_0000);
    push_exp(1, k + 5, 32'h5A00_0004, 32'h0000_0010, 1'b0, 32'h0);
    fork
      req_loop(0, 1'b1, 32'h0000_0300, 32'h7777_0000, 1, 1'b0, 0, 1'b0, 32'h0, 0);
      req_loop(1, 1'b0, 32'h0000_0010, 32'h0, 1, 1'b0, 0, 1'b0, 32'h0, 0);
    join
    @(negedge clk);
    req_loop(0, 1'b0, 32'h0000_0300, 32'h0, 1, 1'b1, 2, 1'b0, 32'h7777_0000, 1);

    // Fixed priority: M0 requesting continuously starves M1.
    @(negedge clk);
    f_m0_stb = 1'b1; f_m1_stb = 1'b1;
    f0 = 0; f1 = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (f_m0_ack) begin
        f0++;
        chk("fix_m0_rdata", f_m0_rdata, 32'h1234_5678);
      end
      if (f_m1_ack) f1++;
      if (i == 8) f_m0_stb = 1'b0;
    end
    chk("fix_m0_acks", 32'(f0), 32'd3);
    chk("fix_m1_acks", 32'(f1), 32'd0);
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      seen = f_m1_ack;
    end
    chk("fix_m1_served", 32'(seen), 32'd1);
    chk("fix_m1_rdata", f_m1_rdata, 32'h1234_5678);
    f_m1_stb = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester 0 is the core load/store unit; requester 1 is the DMA/debug port.
- Serialises requests, drives the memory strobe/write/address/data with registered outputs, and captures read data.
- Returns a one-cycle ack, with an error flag on timeout, to the granted requester.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = fixed priority (M0 wins), 1 = round-robin.
- TIMEOUT_CYC, 15, maximum ACCESS cycles waiting for i_mem_rd_ack before an error response; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_m0_stb  in  1  M0 request; held until o_m0_ack
- i_m0_wr_en  in  1  M0 write (1) / read (0)
- i_m0_addr  in  32  M0 byte address
- i_m0_wdata  in  32  M0 write data
- o_m0_ack  out  1  M0 one-cycle completion pulse
- o_m0_err  out  1  M0 error, valid with o_m0_ack
- o_m0_rdata  out  32  M0 read data, valid with o_m0_ack
- i_m1_stb, i_m1_wr_en, i_m1_addr, i_m1_wdata, o_m1_ack, o_m1_err, o_m1_rdata: identical widths and meaning for M1
- o_mem_stb  out  1  memory strobe
- o_mem_wr_en  out  1  memory write enable
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  memory write data
- i_mem_rd_ack  in  1  memory ready (0 while the memory is in reset)
- i_mem_rdata  in  32  memory read data (combinational from o_mem_addr)

Behaviour:
- Reset: state IDLE. All outputs are 0: acks, errs, rdata, o_mem_stb, o_mem_wr_en, o_mem_addr, o_mem_wdata. Wait counter 0. last_grant = 1, so M0 wins the first tie.
- Reset is asynchronous, so it may hit any state, including mid-transaction. The transaction in flight is aborted and no ack is issued; the requester re-issues after reset.
- Requester contract: stb, wr_en, addr and wdata stay stable from stb rise until the cycle the requester sees ack. The requester may drop stb in that cycle or re-request at the earliest one cycle later.
- Protocol violation: if stb drops early, the transaction still completes and the ack still pulses.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any stb is set, pick a winner and register its wr_en/addr/wdata into the o_mem_* registers.
  - Set o_mem_stb = 1 and o_mem_wr_en = wr_en, then go to ACCESS. Otherwise stay in IDLE.
  - ARB_MODE=0: M0 wins whenever i_m0_stb is set.
  - ARB_MODE=1: a single requester wins outright. On a tie the winner is the requester != last_grant. last_grant updates on each grant.
- ACCESS:
  - If i_mem_rd_ack = 1: capture i_mem_rdata into the winner's rdata register (0 for writes); err = 0. Deassert o_mem_stb and o_mem_wr_en, then go to RESP. The memory write occurs on this edge.
  - If i_mem_rd_ack = 0: increment the counter.
  - When the counter reaches TIMEOUT_CYC: rdata = 0, err = 1, clear stb/wr_en, go to RESP.
  - A repeated write while waiting is harmless: the memory ignores writes while in reset.
- RESP: the winner's o_mX_ack = 1 for exactly one cycle, with err/rdata valid. Clear the counter and go to IDLE.
- The non-winner's ack, err and rdata remain 0 throughout.
- Latency: request in IDLE at cycle N gives ack at cycle N+2 when memory is ready. Each transaction occupies 3 cycles minimum.
- A requester stalled in IDLE by the other requester keeps its request pending. It is not dropped.
- Alignment is not checked by default. Addresses wrap naturally through the 32-bit address; no arithmetic is performed on them.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- Defined: a granted request with addr[1:0] != 0 is never forwarded. o_mem_stb stays 0, the FSM goes IDLE -> RESP directly, and the response is err = 1, rdata = 0, ack at N+1. Arbitration and last_grant update as normal.
- Undefined: misaligned addresses are forwarded unchanged, and err is raised only on timeout.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum (IDLE/ACCESS/RESP)
  - ARB_FIXED = 0, ARB_RR = 1
  - requester index type (1 bit)
  - TIMEOUT counter width = 8
- Sub-module dmem_arb_pick: combinational 2-way picker taking (stb0, stb1, last_grant, mode) and returning (valid, grant_idx). It is reusable for future 2-way shared resources.

Test Plan:
- Single write then read: M0 writes addr 0x100, data 0xDEADBEEF; later M0 reads 0x100. Required: o_mem_stb high for 1 cycle, o_m0_ack at N+2 both times, o_m0_rdata = 0xDEADBEEF, err = 0, no M1 activity.
- Simultaneous requests, ARB_MODE=1: M0 and M1 both read from reset. Required: M0 is served first (ack N+2), then M1 (ack N+5), alternating over 4 back-to-back rounds. ARB_MODE=0 with M0 requesting continuously: M1 is served only when M0 is idle.
- Timeout: hold i_mem_rd_ack = 0 with TIMEOUT_CYC = 15 and M1 reads 0x200. Required: ack at ACCESS + 15 cycles, o_m1_err = 1, o_m1_rdata = 0; next transaction succeeds once rd_ack = 1.
- Reset mid-ACCESS: assert rst during ACCESS of an M0 write. Required: all outputs 0 asynchronously, no ack; after release, M0 re-request completes normally and M0 wins a tie.
- Alignment (macro defined): M0 writes 0x102. Required: o_mem_stb never asserted, o_m0_ack at N+1 with err = 1. Macro undefined: forwarded with addr 0x102, err = 0.
